nor_flash_responder: RTL and testbench



---
 rtl/nor_flash_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 25 ++
 rtl/nor_flash_responder.sv | 141 ++++++++++++++
 tb/tb_nor_flash_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nor_flash_pkg.sv
// Shared opcodes, frame field positions and FSM state type for the NOR flash responder.
package nor_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam int unsigned OP_LSB       = 0;
  localparam int unsigned OP_MSB       = 7;
  localparam int unsigned ADDR_LSB     = 8;
  localparam int unsigned ADDR_MSB     = 31;
  localparam int unsigned ADDR_FIELD_W = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a third flop for edge detection of an asynchronous level.
module sync_edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RESET_VAL}};
    else        sync_q <= {sync_q[1:0], d};
  end

  // Edges are decoded straight off the flops so the consumer acts one cycle later.
  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/nor_flash_responder.sv
// SPI-side NOR flash endpoint: oversampled two-word read/write frames into a small word array.
module nor_flash_responder
  import nor_flash_pkg::*;
#(
  parameter int unsigned LINEWIDE = 32,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                p_clk,
  input  logic                p_resetn,
  input  logic [LINEWIDE-1:0] s_mosi,
  input  logic                s_clk,
  input  logic                s_css,
  output logic [LINEWIDE-1:0] s_miso,
  output logic                busy,
  output logic                frame_done,
  output logic                err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic clk_level, clk_rise, clk_fall;
  logic css_level, css_rise, css_fall;

  sync_edge_det #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk   (p_clk),
    .rst_n (p_resetn),
    .d     (s_clk),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  sync_edge_det #(.RESET_VAL(1'b1)) u_sync_css (
    .clk   (p_clk),
    .rst_n (p_resetn),
    .d     (s_css),
    .level (css_level),
    .rise  (css_rise),
    .fall  (css_fall)
  );

  logic unused_sync;
  assign unused_sync = clk_level ^ clk_fall;

  logic [LINEWIDE-1:0] mosi_d1, mosi_d2;
  logic [LINEWIDE-1:0] mem [DEPTH];
  state_e              state;
  logic                is_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          rst_age;
  logic                armed;

  logic [7:0]              cmd_op;
  logic [ADDR_FIELD_W-1:0] cmd_addr;
  logic                    cmd_in_range;
  logic [ADDR_W-1:0]       cmd_idx;

  assign cmd_op       = mosi_d2[OP_MSB:OP_LSB];
  assign cmd_addr     = mosi_d2[ADDR_MSB:ADDR_LSB];
  assign cmd_in_range = cmd_addr < ADDR_FIELD_W'(DEPTH);
  assign cmd_idx      = cmd_addr[ADDR_W-1:0];

  // Data delay matches the synchronizer depth so the word lines up with the detected edge.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      mosi_d1 <= '0;
      mosi_d2 <= '0;
    end else begin
      mosi_d1 <= s_mosi;
      mosi_d2 <= mosi_d1;
    end
  end

  // A select that was already low across reset must go high once before a frame can open.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      rst_age <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rst_age <= {rst_age[0], 1'b1};
      armed   <= armed | (rst_age[1] & css_level);
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state      <= IDLE;
      s_miso     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      is_write   <= 1'b0;
      addr_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      // Deselect outranks any clock edge seen in the same cycle.
      if (css_rise) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (css_fall && armed) begin
              s_miso <= '0;
              state  <= CMD;
              busy   <= 1'b1;
            end
          end
          CMD: begin
            if (clk_rise) begin
              addr_q <= cmd_idx;
              if (cmd_op == OP_READ && cmd_in_range) begin
                s_miso   <= mem[cmd_idx];
                is_write <= 1'b0;
                state    <= DATA;
              end else if (cmd_op == OP_WRITE && cmd_in_range) begin
                is_write <= 1'b1;
                state    <= DATA;
              end else begin
                err   <= 1'b1;
                state <= DONE;
              end
            end
          end
          DATA: begin
            if (clk_rise) begin
              if (is_write) mem[addr_q] <= mosi_d2;
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nor_flash_responder.sv
// Randomized frame-level bench for nor_flash_responder against a word-array reference model.
module tb_nor_flash_responder;

  localparam int unsigned LW = 32;
  localparam int unsigned DP = 16;

  logic          p_clk = 1'b0;
  logic          p_resetn;
  logic [LW-1:0] s_mosi;
  logic          s_clk;
  logic          s_css;
  logic [LW-1:0] s_miso;
  logic          busy;
  logic          frame_done;
  logic          err;

  always #5 p_clk = ~p_clk;

  nor_flash_responder #(.LINEWIDE(LW), .DEPTH(DP)) dut (
    .p_clk      (p_clk),
    .p_resetn   (p_resetn),
    .s_mosi     (s_mosi),
    .s_clk      (s_clk),
    .s_css      (s_css),
    .s_miso     (s_miso),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  int   fd_cnt = 0;
  int   err_cnt = 0;
  int   wide_pulse = 0;
  logic fd_prev = 1'b0;
  logic err_prev = 1'b0;

  // Pulse counting and single-cycle width tracking.
  always @(negedge p_clk) begin
    fd_cnt     <= fd_cnt + (frame_done ? 1 : 0);
    err_cnt    <= err_cnt + (err ? 1 : 0);
    wide_pulse <= wide_pulse + ((frame_done && fd_prev) ? 1 : 0) + ((err && err_prev) ? 1 : 0);
    fd_prev    <= frame_done;
    err_prev   <= err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [31:0] ref_mem [DP];
  logic [31:0] ref_miso;
  logic [31:0] fw [4];

  task automatic cyc(input int n);
    repeat (n) @(negedge p_clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DP); i++) ref_mem[i] = '0;
    ref_miso = '0;
  endtask

  // Drive one frame of n words from fw[], then check against the reference model.
  task automatic run_frame(input int n, input string tag);
    logic [31:0] pre1;
    logic [7:0]  op;
    logic [23:0] ad;
    logic        ok;
    int          fd0, err0, dfd, derr;
    fd0  = fd_cnt;
    err0 = err_cnt;
    pre1 = '0;
    @(negedge p_clk);
    s_css = 1'b0;
    cyc(4);
    for (int i = 0; i < n; i++) begin
      s_mosi = fw[i];
      cyc(4);
      if (i == 1) pre1 = s_miso;
      s_clk = 1'b1;
      cyc(4);
      s_clk = 1'b0;
    end
    cyc(4);
    chk({tag, " busy_open"}, 32'(busy), 32'd1);
    s_css = 1'b1;
    cyc(6);

    op   = fw[0][7:0];
    ad   = fw[0][31:8];
    ok   = (ad < 24'(DP));
    dfd  = 0;
    derr = 0;
    ref_miso = '0;
    if (n >= 1) begin
      if (op == 8'h01 && ok) begin
        ref_miso = ref_mem[ad];
        if (n >= 2) dfd = 1;
      end else if (op == 8'h02 && ok) begin
        if (n >= 2) begin
          ref_mem[ad] = fw[1];
          dfd = 1;
        end
      end else begin
        derr = 1;
      end
    end
    if (n >= 2) chk({tag, " miso_pre1"}, pre1, ref_miso);
    chk({tag, " frame_done"}, 32'(fd_cnt - fd0), 32'(dfd));
    chk({tag, " err"}, 32'(err_cnt - err0), 32'(derr));
    chk({tag, " miso_held"}, s_miso, ref_miso);
    chk({tag, " busy_closed"}, 32'(busy), 32'd0);
  endtask

  task automatic rd(input int a, input string tag);
    fw[0] = {24'(a), 8'h01};
    fw[1] = $urandom;
    run_frame(2, tag);
  endtask

  initial begin
    int fd0, err0;
    p_resetn = 1'b0;
    s_clk    = 1'b0;
    s_css    = 1'b1;
    s_mosi   = '0;
    model_reset();
    cyc(3);
    chk("reset_miso", s_miso, 32'd0);
    chk("reset_flags", {29'd0, busy, frame_done, err}, 32'd0);
    p_resetn = 1'b1;
    cyc(4);

    rd(5, "read_after_reset");

    fw[0] = 32'h0000_0002; fw[1] = 32'hFF00_FF00;
    run_frame(2, "write0");
    rd(0, "read0");

    fw[0] = 32'h0000_1002; fw[1] = 32'h1111_1111;
    run_frame(2, "oor_write");
    rd(0, "read0_after_oor");

    fw[0] = 32'h0000_0003; fw[1] = 32'h2222_2222;
    run_frame(2, "bad_op");

    fw[0] = 32'h0000_0702; fw[1] = 32'h7777_7777;
    run_frame(1, "abort");
    rd(7, "read7_after_abort");

    fw[0] = 32'h0000_0202; fw[1] = 32'h1234_5678;
    fw[2] = 32'hDEAD_BEEF; fw[3] = 32'hCAFE_F00D;
    run_frame(4, "extra_clk");
    rd(2, "read2");

    fw[0] = 32'h0000_0302; fw[1] = 32'h0303_0303;
    run_frame(2, "pre_reset_write");

    // Reset between word 0 and word 1 of a write.
    fd0  = fd_cnt;
    err0 = err_cnt;
    @(negedge p_clk);
    s_css = 1'b0;
    cyc(4);
    s_mosi = 32'h0000_0302;
    cyc(4);
    s_clk = 1'b1;
    cyc(4);
    s_clk = 1'b0;
    s_mosi = 32'hABCD_0123;
    cyc(2);
    chk("midreset_busy_before", 32'(busy), 32'd1);
    p_resetn = 1'b0;
    #1;
    chk("midreset_outputs", {s_miso[28:0], busy, frame_done, err}, 32'd0);
    model_reset();
    cyc(3);
    p_resetn = 1'b1;
    cyc(4);
    s_clk = 1'b1;
    cyc(4);
    s_clk = 1'b0;
    cyc(4);
    chk("midreset_fd", 32'(fd_cnt - fd0), 32'd0);
    chk("midreset_err", 32'(err_cnt - err0), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    s_css = 1'b1;
    cyc(6);
    rd(3, "read3_after_reset");

    for (int k = 0; k < 40; k++) begin
      int unsigned r, n;
      logic [23:0] a;
      logic [7:0]  op;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      a  = ($urandom_range(0, 5) == 0) ? 24'($urandom_range(16, 300)) : 24'($urandom_range(0, 15));
      r  = $urandom_range(0, 9);
      n  = (r == 0) ? 0 : (r == 1) ? 1 : (r == 9) ? 3 : 2;
      fw[0] = {a, op};
      fw[1] = $urandom;
      fw[2] = $urandom;
      fw[3] = $urandom;
      run_frame(int'(n), $sformatf("rand%0d", k));
    end

    for (int a = 0; a < int'(DP); a++) rd(a, $sformatf("sweep%0d", a));

    chk("pulse_width", 32'(wide_pulse), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
